// File: rtl/odd_one_out_feeder_pkg.sv
// Shared constants and types for the odd_one_out input sequencer.
package odd_one_out_feeder_pkg;

  localparam int unsigned DATA_W  = 8;
  localparam int unsigned PHASE_W = 2;

  typedef enum logic [PHASE_W-1:0] {
    IDLE     = 2'd0,
    LOAD     = 2'd1,
    WAIT_RES = 2'd2,
    DONE     = 2'd3
  } phase_e;

  // Registered output bundle presented to the core and the display
  typedef struct packed {
    logic [DATA_W-1:0] integers;
    logic [DATA_W-1:0] n;
    logic [DATA_W-1:0] remaining;
    logic              latch_in;
    logic              err;
  } feeder_regs_t;

endpackage

// File: rtl/button_debouncer.sv
// Two-flop synchronizer plus counter debouncer; emits a one-cycle pulse on
// each debounced rising edge.
module button_debouncer #(
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  output logic press
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

  logic             sync_q1;
  logic             sync_q2;
  logic             level_q;
  logic             press_q;
  logic [CNT_W-1:0] cnt_q;

  // Counter runs only while the synchronized and debounced levels disagree
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q1 <= 1'b0;
      sync_q2 <= 1'b0;
      level_q <= 1'b0;
      press_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync_q1 <= btn;
      sync_q2 <= sync_q1;
      press_q <= 1'b0;
      if (sync_q2 == level_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CNT_W'(DEBOUNCE_CYCLES)) begin
        level_q <= sync_q2;
        press_q <= sync_q2;
        cnt_q   <= '0;
      end else begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

  assign press = press_q;

endmodule

// File: rtl/odd_one_out_feeder.sv
// Board-side sequencer: captures N from the switches, then issues N integers
// to odd_one_out, one latch_in strobe per debounced enter press.
module odd_one_out_feeder
  import odd_one_out_feeder_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [DATA_W-1:0]  sw,
  input  logic               btn_enter,
  input  logic               btn_clear,
  input  logic               ready,
  output logic [DATA_W-1:0]  integers,
  output logic [DATA_W-1:0]  N,
  output logic               latch_in,
  output logic [DATA_W-1:0]  remaining,
  output logic [PHASE_W-1:0] phase,
  output logic               err
);

  logic         enter_press;
  logic         clear_press;
  logic         ready_q;
  logic         ready_rise;
  phase_e       state_q;
  phase_e       state_d;
  feeder_regs_t regs_q;
  feeder_regs_t regs_d;

  button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_enter_db (
    .clk   (clk),
    .reset (reset),
    .btn   (btn_enter),
    .press (enter_press)
  );

  button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_clear_db (
    .clk   (clk),
    .reset (reset),
    .btn   (btn_clear),
    .press (clear_press)
  );

  // Rise detect keeps a ready left high from a previous run from completing this one
  assign ready_rise = ready & ~ready_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      regs_q  <= '0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      regs_q  <= regs_d;
      ready_q <= ready;
    end
  end

  // Clear overrides any simultaneous enter
  always_comb begin
    state_d = state_q;
    if (clear_press) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:     if (enter_press && sw != '0) state_d = LOAD;
        LOAD:     if (enter_press && regs_q.remaining <= DATA_W'(1)) state_d = WAIT_RES;
        WAIT_RES: if (ready_rise) state_d = DONE;
        DONE:     if (enter_press) state_d = IDLE;
        default:  state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    regs_d          = regs_q;
    regs_d.latch_in = 1'b0;
    if (clear_press) begin
      regs_d.remaining = '0;
      regs_d.err       = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (enter_press) begin
            if (sw != '0) begin
              regs_d.n         = sw;
              regs_d.remaining = sw;
              regs_d.err       = 1'b0;
            end else begin
              regs_d.err = 1'b1;
            end
          end
        end
        LOAD: begin
          if (enter_press && regs_q.remaining != '0) begin
            regs_d.integers  = sw;
            regs_d.latch_in  = 1'b1;
            regs_d.remaining = regs_q.remaining - DATA_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign integers  = regs_q.integers;
  assign N         = regs_q.n;
  assign latch_in  = regs_q.latch_in;
  assign remaining = regs_q.remaining;
  assign err       = regs_q.err;
  assign phase     = state_q;

endmodule

// File: tb/tb_odd_one_out_feeder.sv
// Self-checking bench for odd_one_out_feeder against a press-level model.
module tb_odd_one_out_feeder;
  import odd_one_out_feeder_pkg::*;

  localparam int unsigned DB = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] sw = 8'd0;
  logic       btn_enter = 1'b0;
  logic       btn_clear = 1'b0;
  logic       ready = 1'b0;
  logic [7:0] integers;
  logic [7:0] n_out;
  logic       latch_in;
  logic [7:0] remaining;
  logic [1:0] phase;
  logic       err;

  odd_one_out_feeder #(.DEBOUNCE_CYCLES(DB)) dut (
    .clk       (clk),
    .reset     (reset),
    .sw        (sw),
    .btn_enter (btn_enter),
    .btn_clear (btn_clear),
    .ready     (ready),
    .integers  (integers),
    .N         (n_out),
    .latch_in  (latch_in),
    .remaining (remaining),
    .phase     (phase),
    .err       (err)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Every strobe seen on the interface, with the value it carried
  logic [7:0] strobe_q[$];
  always @(negedge clk) if (reset && latch_in === 1'b1) strobe_q.push_back(integers);

  // Press-level reference model
  int         m_phase;
  logic [7:0] m_n, m_rem, m_int;
  logic       m_err;
  logic [7:0] m_exp_q[$];

  function automatic void m_reset();
    m_phase = 0; m_n = 0; m_rem = 0; m_int = 0; m_err = 0;
    m_exp_q.delete();
  endfunction

  function automatic void m_clear();
    m_phase = 0; m_rem = 0; m_err = 0;
  endfunction

  function automatic void m_enter(input logic [7:0] v);
    case (m_phase)
      0: if (v != 0) begin m_n = v; m_rem = v; m_err = 0; m_phase = 1; end
         else m_err = 1;
      1: begin
        m_int = v; m_exp_q.push_back(v); m_rem = m_rem - 1;
        if (m_rem == 0) m_phase = 2;
      end
      3: m_phase = 0;
      default: ;
    endcase
  endfunction

  // Hold the button(s) long enough to debounce, then let the release settle
  task automatic press(input logic ent, input logic clr, input logic [7:0] v);
    @(negedge clk);
    sw = v; btn_enter = ent; btn_clear = clr;
    repeat (DB + 2) @(negedge clk);
    btn_enter = 1'b0; btn_clear = 1'b0;
    repeat (DB + 8) @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (phase !== 2'd0) begin errors++; $display("FAIL reset_phase: got %0d expected 0", phase); end
    checks++; if (integers !== 8'd0) begin errors++; $display("FAIL reset_integers: got %0d expected 0", integers); end
    checks++; if (n_out !== 8'd0) begin errors++; $display("FAIL reset_n: got %0d expected 0", n_out); end
    checks++; if (latch_in !== 1'b0) begin errors++; $display("FAIL reset_latch: got %0d expected 0", latch_in); end
    checks++; if (remaining !== 8'd0) begin errors++; $display("FAIL reset_remaining: got %0d expected 0", remaining); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err: got %0d expected 0", err); end
    reset = 1'b1;
    m_reset();
    repeat (2) @(negedge clk);
  endtask

  task automatic test_capture();
    strobe_q.delete();
    press(1'b1, 1'b0, 8'd5); m_enter(8'd5);
    checks++; if (phase !== 2'(m_phase)) begin errors++; $display("FAIL capture_phase: got %0d expected %0d", phase, m_phase); end
    checks++; if (n_out !== m_n) begin errors++; $display("FAIL capture_n: got %0d expected %0d", n_out, m_n); end
    checks++; if (remaining !== m_rem) begin errors++; $display("FAIL capture_remaining: got %0d expected %0d", remaining, m_rem); end
    checks++; if (strobe_q.size() != 0) begin errors++; $display("FAIL capture_no_strobe: got %0d expected 0", strobe_q.size()); end
    press(1'b0, 1'b1, 8'd0); m_clear();
    checks++; if (phase !== 2'd0) begin errors++; $display("FAIL capture_clear_phase: got %0d expected 0", phase); end
  endtask

  task automatic test_load();
    logic [7:0] vals [4];
    vals[0] = 8'd7; vals[1] = 8'd9; vals[2] = 8'd7; vals[3] = 8'd42;
    press(1'b1, 1'b0, 8'd3); m_enter(8'd3);
    for (int i = 0; i < 4; i++) begin
      strobe_q.delete(); m_exp_q.delete();
      press(1'b1, 1'b0, vals[i]); m_enter(vals[i]);
      checks++;
      if (strobe_q.size() != m_exp_q.size()) begin
        errors++; $display("FAIL load_strobes[%0d]: got %0d expected %0d", i, strobe_q.size(), m_exp_q.size());
      end else if (m_exp_q.size() == 1) begin
        checks++; if (strobe_q[0] !== m_exp_q[0]) begin errors++; $display("FAIL load_value[%0d]: got %0d expected %0d", i, strobe_q[0], m_exp_q[0]); end
      end
      checks++; if (remaining !== m_rem) begin errors++; $display("FAIL load_remaining[%0d]: got %0d expected %0d", i, remaining, m_rem); end
      checks++; if (phase !== 2'(m_phase)) begin errors++; $display("FAIL load_phase[%0d]: got %0d expected %0d", i, phase, m_phase); end
    end
    checks++; if (integers !== m_int) begin errors++; $display("FAIL load_integers_held: got %0d expected %0d", integers, m_int); end
    press(1'b0, 1'b1, 8'd0); m_clear();
  endtask

  task automatic test_wait_res();
    logic [7:0] v;
    v = 8'($urandom_range(1, 255));
    ready = 1'b1;
    press(1'b1, 1'b0, 8'd1); m_enter(8'd1);
    press(1'b1, 1'b0, v); m_enter(v);
    m_exp_q.delete();
    repeat (5) @(negedge clk);
    checks++; if (phase !== 2'd2) begin errors++; $display("FAIL wait_stale_ready: got %0d expected 2", phase); end
    ready = 1'b0;
    repeat (10) @(negedge clk);
    checks++; if (phase !== 2'd2) begin errors++; $display("FAIL wait_low_ready: got %0d expected 2", phase); end
    ready = 1'b1;
    @(negedge clk);
    m_phase = 3;
    checks++; if (phase !== 2'(m_phase)) begin errors++; $display("FAIL wait_ready_rise: got %0d expected %0d", phase, m_phase); end
    checks++; if (integers !== v) begin errors++; $display("FAIL done_integers: got %0d expected %0d", integers, v); end
    press(1'b1, 1'b0, 8'd0); m_enter(8'd0);
    checks++; if (phase !== 2'(m_phase)) begin errors++; $display("FAIL done_enter_idle: got %0d expected %0d", phase, m_phase); end
    ready = 1'b0;
  endtask

  task automatic test_err();
    press(1'b1, 1'b0, 8'd0); m_enter(8'd0);
    checks++; if (err !== m_err) begin errors++; $display("FAIL err_set: got %0d expected %0d", err, m_err); end
    checks++; if (phase !== 2'(m_phase)) begin errors++; $display("FAIL err_phase: got %0d expected %0d", phase, m_phase); end
    checks++; if (n_out !== m_n) begin errors++; $display("FAIL err_n_held: got %0d expected %0d", n_out, m_n); end
    press(1'b1, 1'b0, 8'd2); m_enter(8'd2);
    checks++; if (err !== m_err) begin errors++; $display("FAIL err_cleared: got %0d expected %0d", err, m_err); end
    checks++; if (phase !== 2'(m_phase)) begin errors++; $display("FAIL err_load: got %0d expected %0d", phase, m_phase); end
    checks++; if (n_out !== m_n) begin errors++; $display("FAIL err_n: got %0d expected %0d", n_out, m_n); end
  endtask

  task automatic test_glitch();
    int hits;
    int first_hit;
    logic [7:0] v;
    v = 8'($urandom_range(0, 255));
    strobe_q.delete();
    @(negedge clk);
    sw = v; btn_enter = 1'b1;
    repeat (DB - 1) @(negedge clk);
    btn_enter = 1'b0;
    repeat (DB + 10) @(negedge clk);
    checks++; if (strobe_q.size() != 0) begin errors++; $display("FAIL glitch_strobe: got %0d expected 0", strobe_q.size()); end
    checks++; if (remaining !== m_rem) begin errors++; $display("FAIL glitch_remaining: got %0d expected %0d", remaining, m_rem); end
    hits = 0; first_hit = -1;
    btn_enter = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      @(negedge clk);
      if (i == DB + 2) btn_enter = 1'b0;
      if (latch_in === 1'b1) begin
        hits++;
        if (first_hit < 0) first_hit = i;
      end
    end
    m_enter(v); m_exp_q.delete();
    checks++; if (hits != 1) begin errors++; $display("FAIL press_strobe_count: got %0d expected 1", hits); end
    checks++; if (first_hit != int'(DB) + 4) begin errors++; $display("FAIL press_latency: got %0d expected %0d", first_hit, DB + 4); end
    checks++; if (integers !== v) begin errors++; $display("FAIL press_integers: got %0d expected %0d", integers, v); end
    checks++; if (remaining !== m_rem) begin errors++; $display("FAIL press_remaining: got %0d expected %0d", remaining, m_rem); end
  endtask

  task automatic test_clear_and_enter();
    strobe_q.delete();
    press(1'b1, 1'b1, 8'd99); m_clear();
    checks++; if (strobe_q.size() != 0) begin errors++; $display("FAIL both_no_strobe: got %0d expected 0", strobe_q.size()); end
    checks++; if (phase !== 2'(m_phase)) begin errors++; $display("FAIL both_phase: got %0d expected %0d", phase, m_phase); end
    checks++; if (remaining !== m_rem) begin errors++; $display("FAIL both_remaining: got %0d expected %0d", remaining, m_rem); end
    checks++; if (n_out !== m_n) begin errors++; $display("FAIL both_n_held: got %0d expected %0d", n_out, m_n); end
    checks++; if (integers !== m_int) begin errors++; $display("FAIL both_integers_held: got %0d expected %0d", integers, m_int); end
  endtask

  task automatic test_async_reset();
    press(1'b1, 1'b0, 8'd4); m_enter(8'd4);
    press(1'b1, 1'b0, 8'hA5); m_enter(8'hA5); m_exp_q.delete();
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    checks++; if ({phase, integers, n_out, latch_in, remaining, err} !== 28'd0) begin
      errors++; $display("FAIL async_reset: got phase=%0d int=%0d n=%0d rem=%0d err=%0d expected all 0", phase, integers, n_out, remaining, err);
    end
    @(negedge clk);
    reset = 1'b1; m_reset();
    repeat (2) @(negedge clk);
  endtask

  task automatic test_random();
    for (int run = 0; run < 4; run++) begin
      logic [7:0] nv;
      nv = 8'($urandom_range(1, 5));
      ready = 1'b0;
      press(1'b1, 1'b0, nv); m_enter(nv);
      checks++; if (n_out !== m_n) begin errors++; $display("FAIL rand_n[%0d]: got %0d expected %0d", run, n_out, m_n); end
      for (int j = 0; j < int'(nv); j++) begin
        logic [7:0] v;
        v = 8'($urandom_range(0, 255));
        strobe_q.delete(); m_exp_q.delete();
        press(1'b1, 1'b0, v); m_enter(v);
        checks++;
        if (strobe_q.size() != m_exp_q.size()) begin
          errors++; $display("FAIL rand_strobes[%0d.%0d]: got %0d expected %0d", run, j, strobe_q.size(), m_exp_q.size());
        end else if (m_exp_q.size() == 1) begin
          checks++; if (strobe_q[0] !== m_exp_q[0]) begin errors++; $display("FAIL rand_value[%0d.%0d]: got %0d expected %0d", run, j, strobe_q[0], m_exp_q[0]); end
        end
        checks++; if (remaining !== m_rem) begin errors++; $display("FAIL rand_remaining[%0d.%0d]: got %0d expected %0d", run, j, remaining, m_rem); end
      end
      checks++; if (phase !== 2'(m_phase)) begin errors++; $display("FAIL rand_wait[%0d]: got %0d expected %0d", run, phase, m_phase); end
      repeat ($urandom_range(1, 8)) @(negedge clk);
      ready = 1'b1;
      @(negedge clk);
      m_phase = 3;
      checks++; if (phase !== 2'(m_phase)) begin errors++; $display("FAIL rand_done[%0d]: got %0d expected %0d", run, phase, m_phase); end
      press(1'b1, 1'b0, 8'd0); m_enter(8'd0);
      checks++; if (phase !== 2'(m_phase)) begin errors++; $display("FAIL rand_idle[%0d]: got %0d expected %0d", run, phase, m_phase); end
    end
    ready = 1'b0;
  endtask

  initial begin
    m_reset();
    test_reset();
    test_capture();
    test_load();
    test_wait_res();
    test_err();
    test_glitch();
    test_clear_and_enter();
    test_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
